fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of the decode stage.
- Holds the 8-bit program counter and reads each 16-bit instruction as two byte reads (high byte at pc, low byte at pc+1) over a req/ack memory port.
- Presents the assembled word to decode with a level enable, held until decode reports ready.
- Accepts PC loads (jump/branch/reset vector) from the control path.

Parameters:
RESET_PC, 8'h00, PC value after reset
TIMEOUT_CYCLES, 16, cycles without mem_ack before a fetch fault (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  control request to fetch the next instruction; sampled in IDLE
pc_load  input  1  load PC from pc_in
pc_in  input  8  new PC value
mem_req  output  1  memory read request
mem_addr  output  8  byte address of current read
mem_ack  input  1  read data valid; one-cycle pulse per byte
mem_rdata  input  8  read data, valid when mem_ack=1
inst  output  16  assembled instruction to decode
dec_en  output  1  enable to decode; inst is stable while high
dec_ready  input  1  decode has latched inst
pc  output  8  current PC (address of the instruction being fetched)
busy  output  1  1 when state != IDLE
fault  output  1  sticky fetch fault (constant 0 without FETCH_TIMEOUT_EN)

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, inst=0, mem_req=0, mem_addr=0, dec_en=0, busy=0, fault=0, pending load cleared.
  - Takes effect immediately mid-transaction; mem_req and dec_en drop without waiting for a clock.
- States: IDLE, RD_HI, RD_LO, ISSUE. All outputs are registered.
- IDLE:
  - pc_load=1: pc<=pc_in, fault<=0, stay IDLE. pc_load has priority over en in the same cycle.
  - Else en=1: mem_req<=1, mem_addr<=pc, go to RD_HI.
- RD_HI: on mem_ack=1: inst[15:8]<=mem_rdata, mem_addr<=pc+1 (8-bit wrap: 8'hFF+1 = 8'h00), mem_req stays 1, go to RD_LO.
- RD_LO: on mem_ack=1: inst[7:0]<=mem_rdata, mem_req<=0, dec_en<=1, go to ISSUE.
- ISSUE:
  - dec_en held high and inst held constant until dec_ready=1 is sampled.
  - Then dec_en<=0, pc<=pc+2 (mod 256; 8'hFE → 8'h00), go to IDLE.
  - Minimum fetch-to-issue latency with zero-wait memory is 3 cycles after en.
  - Decode needs dec_en for two consecutive edges before asserting ready; this block must never drop dec_en early.
- pc_load while busy:
  - Captured as a pending load and does not disturb the transaction.
  - On the ISSUE→IDLE transition, the pending value replaces pc+2.
  - A later pc_load in the same transaction overwrites an earlier one.
- mem_ack in IDLE or ISSUE is ignored.
- dec_ready outside ISSUE is ignored.
- en while busy is ignored; requests are not queued.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter runs in RD_HI and RD_LO and clears on each mem_ack.
  - If it reaches TIMEOUT_CYCLES with no ack: mem_req<=0, fault<=1, go to IDLE; pc unchanged, dec_en never asserted, any pending load applied.
  - fault is sticky and clears only on reset or pc_load.
  - While fault=1, en is ignored.
- Undefined: no counter, fault tied to 0, the block waits indefinitely for mem_ack.

Test Plan:
1. Reset, then en=1 with memory returning 8'h12 at 0x00 and 8'h34 at 0x01 (zero wait) → inst=16'h1234 and dec_en=1 three cycles after en; after dec_ready, pc=8'h02 and busy=0.
2. pc_load=1, pc_in=8'hFE, then en → mem_addr sequence FE, FF; after issue, pc=8'h00.
3. Memory inserts 3 wait cycles per byte → mem_req stays high and mem_addr stays stable through the waits; inst is correct; dec_en holds for 5 cycles when dec_ready is delayed 5 cycles.
4. pc_load with pc_in=8'h40 asserted during RD_LO → fetch completes with the old inst; after dec_ready, pc=8'h40 (not pc+2).
5. rst_n pulled low in RD_LO → mem_req and dec_en drop immediately, pc=RESET_PC; a subsequent fetch from RESET_PC succeeds.
6. (FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16) No mem_ack → fault=1 and mem_req=0 after 16 cycles; en is ignored; pc_load clears fault.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: 8-bit PC, each 16-bit word read as two bytes (high at pc, low at pc+1).
// Build macro FETCH_TIMEOUT_EN adds a mem_ack watchdog with a sticky fault flag.
module fetch_unit #(
  parameter logic [7:0] RESET_PC       = 8'h00,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        pc_load,
  input  logic [7:0]  pc_in,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] inst,
  output logic        dec_en,
  input  logic        dec_ready,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  pc_nxt, mem_addr_nxt, pend_pc, pend_pc_nxt, load_val;
  logic [15:0] inst_nxt;
  logic        mem_req_nxt, dec_en_nxt, pend_valid, pend_valid_nxt, load_any;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
  end

  // A pc_load landing on the same edge the transaction ends still counts as the latest load.
  assign load_any = pc_load | pend_valid;
  assign load_val = pc_load ? pc_in : pend_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             reading, timed_out, fault_nxt;

  assign reading   = (state == RD_HI) || (state == RD_LO);
  assign timed_out = reading && !mem_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      fault <= fault_nxt;
      if (!reading || mem_ack || timed_out)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    inst_nxt       = inst;
    mem_req_nxt    = mem_req;
    mem_addr_nxt   = mem_addr;
    dec_en_nxt     = dec_en;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
`ifdef FETCH_TIMEOUT_EN
    fault_nxt      = fault;
`endif

    if (state != IDLE && pc_load) begin
      pend_valid_nxt = 1'b1;
      pend_pc_nxt    = pc_in;
    end

    unique case (state)
      IDLE: begin
        if (pc_load) begin
          pc_nxt = pc_in;
        end else if (en && !fault) begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = pc;
          state_nxt    = RD_HI;
        end
      end
      RD_HI: begin
        if (mem_ack) begin
          inst_nxt[15:8] = mem_rdata;
          mem_addr_nxt   = pc + 8'd1;
          state_nxt      = RD_LO;
        end
      end
      RD_LO: begin
        if (mem_ack) begin
          inst_nxt[7:0] = mem_rdata;
          mem_req_nxt   = 1'b0;
          dec_en_nxt    = 1'b1;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (dec_ready) begin
          dec_en_nxt     = 1'b0;
          pc_nxt         = load_any ? load_val : pc + 8'd2;
          pend_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef FETCH_TIMEOUT_EN
    if (state == IDLE && pc_load)
      fault_nxt = 1'b0;
    // Abandon the read; the PC stays on the faulting instruction unless a load arrived.
    if (timed_out) begin
      mem_req_nxt    = 1'b0;
      fault_nxt      = 1'b1;
      pc_nxt         = load_any ? load_val : pc;
      pend_valid_nxt = 1'b0;
      state_nxt      = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inst       <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      dec_en     <= 1'b0;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
      dec_en     <= dec_en_nxt;
      busy       <= (state_nxt != IDLE);
      pend_valid <= pend_valid_nxt;
      pend_pc    <= pend_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, reset/timeout sequences, and randomized fetches
// checked against a transaction-level model (word = {mem[pc], mem[pc+1]}, next pc = last load or pc+2).
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [7:0] RST_PC = 8'h00;
  localparam int         TMO    = 16;

  logic        clk = 1'b0;
  logic        rst_n, en, pc_load, dec_ready;
  logic [7:0]  pc_in;
  logic        mem_req, dec_en, busy, fault;
  logic [7:0]  mem_addr, pc;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] inst;

  fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc_load(pc_load), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst(inst), .dec_en(dec_en), .dec_ready(dec_ready), .pc(pc), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_load;
    logic [7:0]  load_pc;
    logic [7:0]  addr_hi;
    logic [7:0]  addr_lo;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          waits;
    int          rdy;
    int          mid_at;
    logic [7:0]  mid_val;
    bit          iss_load;
    logic [7:0]  iss_val;
    bit          noise;
    logic [15:0] exp_inst;
    logic [7:0]  exp_pc;
    int          exp_lat;
  } vec_t;

  logic [7:0] mem [256];
  int         wait_cfg = 0;
  bit         mem_on = 1'b1;
  bit         stray_on = 1'b0;
  int         wcnt = 0;
  logic [7:0] start_addr = 8'h00;
  int         addr_moved = 0;
  int         req_dropped = 0;
  logic [7:0] acked [$];
  int         n_checks = 0;
  int         n_fail = 0;

  vec_t       tbl [7];
  vec_t       v;
  logic [7:0] m_pc, start;

  // Memory answers mem_rdata after wait_cfg idle cycles per byte; stray acks only when no request.
  always @(negedge clk) begin
    if (mem_req && mem_on) begin
      if (wcnt == 0)
        start_addr = mem_addr;
      else if (mem_addr != start_addr)
        addr_moved++;
      if (wcnt >= wait_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        acked.push_back(mem_addr);
        wcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      if (wcnt != 0)
        req_dropped++;
      wcnt      = 0;
      mem_ack   = stray_on ? 1'($urandom) : 1'b0;
      mem_rdata = 8'($urandom);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t s);
    int cyc;
    wait_cfg = s.waits;
    stray_on = s.noise;
    mem[s.addr_hi] = s.hi;
    mem[s.addr_lo] = s.lo;
    acked.delete();
    addr_moved  = 0;
    req_dropped = 0;
    if (s.do_load) begin
      pc_load = 1'b1; pc_in = s.load_pc; en = 1'b1;
      tick();
      pc_load = 1'b0; en = 1'b0;
      checkOutput("idle load pc", pc, s.load_pc);
      checkOutput("load beats en", busy, 0);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    checkOutput("busy after en", busy, 1);
    cyc = 0;
    while (!dec_en && cyc < 100) begin
      pc_load = (cyc == s.mid_at);
      pc_in   = s.mid_val;
      if (s.noise) begin
        en        = 1'($urandom);
        dec_ready = 1'($urandom);
      end
      tick();
      cyc++;
    end
    pc_load = 1'b0; en = 1'b0; dec_ready = 1'b0;
    checkOutput("issue latency", cyc + 1, s.exp_lat);
    checkOutput("inst", inst, s.exp_inst);
    for (int d = 0; d < s.rdy; d++) begin
      if (d == 0 && s.iss_load) begin
        pc_load = 1'b1; pc_in = s.iss_val;
      end
      tick();
      pc_load = 1'b0;
      checkOutput("dec_en held", dec_en, 1);
      checkOutput("inst held", inst, s.exp_inst);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    checkOutput("dec_en drop", dec_en, 0);
    checkOutput("busy after issue", busy, 0);
    checkOutput("pc after issue", pc, s.exp_pc);
    checkOutput("fault", fault, 0);
    checkOutput("read count", acked.size(), 2);
    if (acked.size() >= 2) begin
      checkOutput("addr hi", acked[0], s.addr_hi);
      checkOutput("addr lo", acked[1], s.addr_lo);
    end
    checkOutput("addr stable in wait", addr_moved, 0);
    checkOutput("req held in wait", req_dropped, 0);
    stray_on = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; pc_load = 1'b0; pc_in = 8'h00; dec_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    tbl[0] = '{1'b0, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 0, 0, -1, 8'h00, 1'b0, 8'h00, 1'b0, 16'h1234, 8'h02, 3};
    tbl[1] = '{1'b1, 8'hFE, 8'hFE, 8'hFF, 8'hAB, 8'hCD, 0, 1, -1, 8'h00, 1'b0, 8'h00, 1'b0, 16'hABCD, 8'h00, 3};
    tbl[2] = '{1'b0, 8'h00, 8'h00, 8'h01, 8'h9C, 8'h3E, 3, 5, -1, 8'h00, 1'b0, 8'h00, 1'b0, 16'h9C3E, 8'h02, 9};
    tbl[3] = '{1'b0, 8'h00, 8'h02, 8'h03, 8'h11, 8'h22, 0, 0,  1, 8'h40, 1'b0, 8'h00, 1'b0, 16'h1122, 8'h40, 3};
    tbl[4] = '{1'b1, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h01, 1, 2,  2, 8'h10, 1'b1, 8'h33, 1'b0, 16'h8001, 8'h33, 5};
    tbl[5] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'h5A, 8'hA5, 2, 1, -1, 8'h00, 1'b0, 8'h00, 1'b0, 16'h5AA5, 8'h01, 7};
    tbl[6] = '{1'b0, 8'h00, 8'h01, 8'h02, 8'hE7, 8'h18, 0, 3, -1, 8'h00, 1'b1, 8'hC8, 1'b0, 16'hE718, 8'hC8, 3};

    repeat (2) tick();
    checkOutput("reset mem_req", mem_req, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset dec_en", dec_en, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset pc", pc, RST_PC);
    checkOutput("reset inst", inst, 0);
    checkOutput("reset fault", fault, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) applyStimulus(tbl[i]);

    // Asynchronous reset while the low byte is outstanding
    wait_cfg = 0;
    pc_load = 1'b1; pc_in = 8'h60;
    tick();
    pc_load = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    checkOutput("mem_req in RD_LO", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst mem_req", mem_req, 0);
    checkOutput("async rst busy", busy, 0);
    checkOutput("async rst pc", pc, RST_PC);
    checkOutput("async rst mem_addr", mem_addr, 0);
    tick();
    rst_n = 1'b1;
    v = '{1'b0, 8'h00, 8'h00, 8'h01, 8'hC3, 8'h5E, 0, 0, -1, 8'h00, 1'b0, 8'h00, 1'b0, 16'hC35E, 8'h02, 3};
    applyStimulus(v);

    // Asynchronous reset while the word is being presented to decode
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    checkOutput("dec_en before reset", dec_en, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst dec_en", dec_en, 0);
    checkOutput("async rst inst", inst, 0);
    checkOutput("async rst pc issue", pc, RST_PC);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef FETCH_TIMEOUT_EN
    for (int t = 0; t < 2; t++) begin
      pc_load = 1'b1; pc_in = 8'h50;
      tick();
      pc_load = 1'b0;
      mem_on = 1'b0;
      en = 1'b1;
      tick();
      en = 1'b0;
      for (int c = 1; c < TMO; c++) begin
        if (t == 1 && c == 3) begin
          pc_load = 1'b1; pc_in = 8'h77;
        end
        tick();
        pc_load = 1'b0;
      end
      checkOutput("no fault before limit", fault, 0);
      checkOutput("mem_req before limit", mem_req, 1);
      checkOutput("mem_addr while waiting", mem_addr, 8'h50);
      tick();
      checkOutput("timeout fault", fault, 1);
      checkOutput("timeout mem_req", mem_req, 0);
      checkOutput("timeout busy", busy, 0);
      checkOutput("timeout dec_en", dec_en, 0);
      checkOutput("timeout pc", pc, (t == 1) ? 8'h77 : 8'h50);
      en = 1'b1;
      tick();
      en = 1'b0;
      checkOutput("en ignored in fault", busy, 0);
      checkOutput("no req in fault", mem_req, 0);
      checkOutput("fault sticky", fault, 1);
      pc_load = 1'b1; pc_in = 8'h20;
      tick();
      pc_load = 1'b0;
      checkOutput("pc_load clears fault", fault, 0);
      checkOutput("pc_load after fault", pc, 8'h20);
      mem_on = 1'b1;
      tick();
    end
`endif

    // Randomized fetches; first one loads the PC so the model starts from a known value
    m_pc = RST_PC;
    for (int r = 0; r < 40; r++) begin
      v.do_load  = (r == 0) || ($urandom_range(0, 3) == 0);
      v.load_pc  = 8'($urandom);
      start      = v.do_load ? v.load_pc : m_pc;
      v.addr_hi  = start;
      v.addr_lo  = start + 8'd1;
      v.hi       = 8'($urandom);
      v.lo       = 8'($urandom);
      v.waits    = int'($urandom_range(0, 3));
      v.rdy      = int'($urandom_range(0, 3));
      v.exp_lat  = 3 + 2 * v.waits;
      v.mid_at   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, v.exp_lat - 2)) : -1;
      v.mid_val  = 8'($urandom);
      v.iss_load = (v.rdy > 0) && ($urandom_range(0, 2) == 0);
      v.iss_val  = 8'($urandom);
      v.noise    = 1'b1;
      v.exp_inst = {v.hi, v.lo};
      if (v.iss_load)
        v.exp_pc = v.iss_val;
      else if (v.mid_at >= 0)
        v.exp_pc = v.mid_val;
      else
        v.exp_pc = start + 8'd2;
      applyStimulus(v);
      m_pc = v.exp_pc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
